// File: rtl/insn_fetch_if.sv
// Instruction-memory channel between the fetch front end and instruction memory.
// Requests hold until granted; read data returns in order, one word per rvalid.
interface insn_fetch_if #(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 32
);
    logic                  req;
    logic [PC_WIDTH-1:0]   addr;
    logic                  gnt;
    logic                  rvalid;
    logic [WORD_WIDTH-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch front end: in-order imem requests, 2-entry instruction
// buffer, static backward-taken prediction on the head and flush redirect.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no request on the bus
// ST_REQ  | request driven on the bus, address held until granted
module insn_fetch #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    WORD_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [WORD_WIDTH-1:0] NOP_INSN   = 'h13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_en,
    input  logic                  if_stall,
    input  logic                  if_flush,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    insn_fetch_if.master          imem,
    output logic                  insn_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [WORD_WIDTH-1:0] insn,
    output logic                  predt_br_taken
);

    typedef enum logic {ST_IDLE, ST_REQ} req_state_t;

    req_state_t state, state_nxt;

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   req_addr;
    logic [PC_WIDTH-1:0]   rsp_pc;
    logic [1:0]            outstanding;
    logic [1:0]            drop_cnt;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [WORD_WIDTH-1:0] buf_insn [2];
    logic [PC_WIDTH-1:0]   buf_pc   [2];

    logic                  req_pend;
    logic [2:0]            credit_used;
    logic                  head_valid;
    logic [WORD_WIDTH-1:0] head_insn;
    logic [PC_WIDTH-1:0]   head_pc;
    logic                  is_jal;
    logic                  is_bneg;
    logic                  predict_taken;
    logic [PC_WIDTH-1:0]   j_imm;
    logic [PC_WIDTH-1:0]   b_imm;
    logic [PC_WIDTH-1:0]   br_target;
    logic [PC_WIDTH-1:0]   new_pc;
    logic                  consume;
    logic                  redirect;
    logic                  issue;
    logic                  wr_en;
    logic                  rsp_drop;

    assign req_pend    = (state == ST_REQ);
    assign imem.req    = req_pend;
    assign imem.addr   = req_addr;

    assign head_valid  = (count != 2'd0);
    assign head_insn   = buf_insn[rd_ptr];
    assign head_pc     = buf_pc[rd_ptr];

    assign is_jal      = (head_insn[6:0] == 7'b1101111);
    assign is_bneg     = (head_insn[6:0] == 7'b1100011) && head_insn[31];
    assign predict_taken = is_jal || is_bneg;
    assign j_imm = {{(PC_WIDTH-21){head_insn[31]}}, head_insn[31], head_insn[19:12],
                    head_insn[20], head_insn[30:21], 1'b0};
    assign b_imm = {{(PC_WIDTH-13){head_insn[31]}}, head_insn[31], head_insn[7],
                    head_insn[30:25], head_insn[11:8], 1'b0};
    assign br_target = head_pc + (is_jal ? j_imm : b_imm);
    assign new_pc    = if_flush ? (redirect_pc & ~PC_WIDTH'(3)) : (br_target & ~PC_WIDTH'(3));

    assign consume  = head_valid && cpu_en && !if_stall && !if_flush;
    assign redirect = if_flush || (consume && predict_taken);

    // A request being granted this cycle still occupies its credit (it becomes
    // outstanding), so the slot count never exceeds the two buffer entries.
    assign credit_used = 3'(outstanding) + 3'(count) + 3'(req_pend);
    assign issue = cpu_en && !redirect && (credit_used < 3'd2) && (!req_pend || imem.gnt);

    assign rsp_drop = imem.rvalid && (drop_cnt != 2'd0);
    assign wr_en    = imem.rvalid && (drop_cnt == 2'd0) && !redirect;

    // Request state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Request next-state: raise on issue, drop after grant unless reissuing.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_REQ;
            ST_REQ:  if (imem.gnt && !issue) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // PCs, credit counters and buffer pointers. fetch_pc advances when a
    // request is issued so a redirect can overwrite it while an older request
    // is still waiting for its grant. On redirect every response still in
    // flight (already counted in outstanding) is marked for dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            req_addr    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            outstanding <= outstanding + 2'(req_pend && imem.gnt) - 2'(imem.rvalid);
            if (issue) req_addr <= fetch_pc;
            if (redirect) begin
                fetch_pc <= new_pc;
                rsp_pc   <= new_pc;
                drop_cnt <= outstanding - 2'(imem.rvalid) + 2'(req_pend);
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (issue)    fetch_pc <= fetch_pc + PC_WIDTH'(4);
                if (rsp_drop) drop_cnt <= drop_cnt - 2'd1;
                if (wr_en) begin
                    rsp_pc <= rsp_pc + PC_WIDTH'(4);
                    wr_ptr <= ~wr_ptr;
                end
                if (consume) rd_ptr <= ~rd_ptr;
                count <= count + 2'(wr_en) - 2'(consume);
            end
        end
    end

    // Buffer storage; entries are only meaningful where count marks them valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_insn[wr_ptr] <= imem.rdata;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // Head presentation; forced to the idle values when empty or flushing.
    always_comb begin
        insn_valid     = 1'b0;
        pc             = '0;
        insn           = NOP_INSN;
        predt_br_taken = 1'b0;
        if (head_valid && !if_flush) begin
            insn_valid     = 1'b1;
            pc             = head_pc;
            insn           = head_insn;
            predt_br_taken = predict_taken;
        end
    end

endmodule
